// File: rtl/am_radio_broadcast_sequencer_pkg.sv
// am_radio_pkg
//   Shared definitions for the AM broadcast sequencer: sequencer state
//   encodings (also exported on the status register), the state field width
//   and the status-word bit positions for seq_state and on_air.
package am_radio_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    SEQ_IDLE      = 3'd0,
    SEQ_RAMP_UP   = 3'd1,
    SEQ_ON_AIR    = 3'd2,
    SEQ_RAMP_DOWN = 3'd3,
    SEQ_COOLDOWN  = 3'd4,
    SEQ_FAULT     = 3'd5
  } seq_state_e;

  // Status register layout: seq_state in [2:0], on_air in bit 3.
  localparam int STAT_SEQ_STATE_LSB = 0;
  localparam int STAT_ON_AIR_BIT    = STAT_SEQ_STATE_LSB + SEQ_STATE_W;

  // States in which the message BRAM is being read.
  function automatic logic is_streaming(seq_state_e s);
    return (s == SEQ_RAMP_UP) || (s == SEQ_ON_AIR) || (s == SEQ_RAMP_DOWN);
  endfunction

endpackage

// File: rtl/am_radio_broadcast_sequencer_if.sv
// am_radio_broadcast_sequencer_if
//   Bundles the sequencer's control inputs and its BRAM / modulator / status
//   outputs.
//   master: control side (drives start_req, abort, sample_tick, message_id,
//           loop_en; observes bram_addr, bram_en, gain, on_air, seq_state, done)
//   slave : the sequencer itself (the reverse directions)
interface am_radio_broadcast_sequencer_if
  import am_radio_pkg::*;
#(
  parameter int SLOT_W   = 10,
  parameter int MSG_ID_W = 4,
  parameter int GAIN_W   = 8
);
  logic                       start_req;
  logic                       abort;
  logic                       sample_tick;
  logic [7:0]                 message_id;
  logic                       loop_en;
  logic [MSG_ID_W+SLOT_W-1:0] bram_addr;
  logic                       bram_en;
  logic [GAIN_W-1:0]          gain;
  logic                       on_air;
  logic [SEQ_STATE_W-1:0]     seq_state;
  logic                       done;

  modport master (
    output start_req, abort, sample_tick, message_id, loop_en,
    input  bram_addr, bram_en, gain, on_air, seq_state, done
  );

  modport slave (
    input  start_req, abort, sample_tick, message_id, loop_en,
    output bram_addr, bram_en, gain, on_air, seq_state, done
  );
endinterface

// File: rtl/am_radio_broadcast_sequencer_gain_ramp.sv
// am_gain_ramp
//   Saturating up/down gain counter used for the carrier soft start / stop.
//   Ports: clk, rst_n (async, active-low); up/down step the gain by RAMP_STEP
//   on a tick; clr forces the gain to zero on the next clk regardless of tick.
//   gain is the registered output. at_max / at_zero describe the value gain
//   takes at this clock edge, so the controller can change state on the same
//   edge that the gain reaches its limit.
module am_gain_ramp #(
  parameter int GAIN_W    = 8,
  parameter int GAIN_MAX  = 255,
  parameter int RAMP_STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up,
  input  logic              down,
  input  logic              clr,
  input  logic              tick,
  output logic [GAIN_W-1:0] gain,
  output logic              at_max,
  output logic              at_zero
);
  localparam logic [GAIN_W:0] STEP_X = (GAIN_W+1)'(RAMP_STEP);
  localparam logic [GAIN_W:0] MAX_X  = (GAIN_W+1)'(GAIN_MAX);

  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [GAIN_W:0]   sum_x, up_x;
  logic [GAIN_W-1:0] dn_val;

  always_comb begin
    // One extra bit so the add cannot wrap before saturation.
    sum_x  = {1'b0, gain_q} + STEP_X;
    up_x   = (sum_x > MAX_X) ? MAX_X : sum_x;
    dn_val = ({1'b0, gain_q} > STEP_X) ? (gain_q - STEP_X[GAIN_W-1:0]) : '0;
    gain_d = gain_q;
    if (clr)
      gain_d = '0;
    else if (tick && up)
      gain_d = up_x[GAIN_W-1:0];
    else if (tick && down)
      gain_d = dn_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gain_q <= '0;
    else        gain_q <= gain_d;
  end

  assign gain    = gain_q;
  assign at_max  = (gain_d == MAX_X[GAIN_W-1:0]);
  assign at_zero = (gain_d == '0);
endmodule

// File: rtl/am_radio_broadcast_sequencer.sv
// am_radio_broadcast_sequencer
//   Sequences one AM broadcast: soft-start / soft-stop carrier gain envelope,
//   message BRAM read addressing ({slot, offset}), cooldown and watchdog fault.
//   Ports: clk, rst_n (async, active-low), bus (slave modport) carrying
//   start_req, abort, sample_tick, message_id, loop_en in and bram_addr,
//   bram_en, gain, on_air, seq_state, done out. All outputs are registered.
module am_radio_broadcast_sequencer
  import am_radio_pkg::*;
#(
  parameter int CLK_FREQ       = 125_000_000,
  parameter int SLOT_W         = 10,
  parameter int MSG_ID_W       = 4,
  parameter int GAIN_W         = 8,
  parameter int GAIN_MAX       = 255,
  parameter int RAMP_STEP      = 1,
  parameter int COOLDOWN_TICKS = 64
) (
  input logic                         clk,
  input logic                         rst_n,
  am_radio_broadcast_sequencer_if.slave bus
);
  localparam int CD_W = (COOLDOWN_TICKS < 2) ? 1 : $clog2(COOLDOWN_TICKS + 1);
  localparam logic [CD_W-1:0]   CD_LOAD = CD_W'(COOLDOWN_TICKS);
  localparam logic [SLOT_W-1:0] OFF_MAX = '1;
  // Clock frequency is informational only.
  localparam int unused_clk_freq = CLK_FREQ;

  seq_state_e          state_q;
  logic [MSG_ID_W-1:0] slot_q;
  logic [SLOT_W-1:0]   off_q;
  logic [CD_W-1:0]     cd_q;
  logic                bram_en_q;
  logic                on_air_q;
  logic                done_q;

  logic              tick;
  logic              at_end;
  logic              end_stop;
  logic              ramp_up, ramp_down, ramp_clr;
  logic              at_max, at_zero;
  logic [GAIN_W-1:0] gain;

  assign tick     = bus.sample_tick;
  assign at_end   = (off_q == OFF_MAX);
  // Last sample of a one-shot message: this tick ends playback.
  assign end_stop = tick && at_end && !bus.loop_en;

  // The tick that turns RAMP_UP around (request dropped or message ended)
  // leaves the gain where it is; the descent starts on the following tick.
  assign ramp_up   = (state_q == SEQ_RAMP_UP) && bus.start_req && !end_stop;
  assign ramp_down = (state_q == SEQ_RAMP_DOWN);
  assign ramp_clr  = bus.abort || (state_q == SEQ_IDLE);

  am_gain_ramp #(
    .GAIN_W   (GAIN_W),
    .GAIN_MAX (GAIN_MAX),
    .RAMP_STEP(RAMP_STEP)
  ) u_gain_ramp (
    .clk    (clk),
    .rst_n  (rst_n),
    .up     (ramp_up),
    .down   (ramp_down),
    .clr    (ramp_clr),
    .tick   (tick),
    .gain   (gain),
    .at_max (at_max),
    .at_zero(at_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEQ_IDLE;
      slot_q    <= '0;
      off_q     <= '0;
      cd_q      <= '0;
      bram_en_q <= 1'b0;
      on_air_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      on_air_q <= !at_zero;
      if (bus.abort) begin
        state_q   <= SEQ_FAULT;
        bram_en_q <= 1'b0;
        off_q     <= '0;
      end else begin
        if (is_streaming(state_q) && tick) begin
          if (!at_end)          off_q <= off_q + 1'b1;
          else if (bus.loop_en) off_q <= '0;
        end
        case (state_q)
          SEQ_IDLE: begin
            if (bus.start_req) begin
              state_q   <= SEQ_RAMP_UP;
              slot_q    <= bus.message_id[MSG_ID_W-1:0];
              off_q     <= '0;
              bram_en_q <= 1'b1;
            end
          end
          SEQ_RAMP_UP: begin
            if (tick) begin
              if (!bus.start_req || end_stop) state_q <= SEQ_RAMP_DOWN;
              else if (at_max)                state_q <= SEQ_ON_AIR;
            end
          end
          SEQ_ON_AIR: begin
            if (tick && (!bus.start_req || end_stop)) state_q <= SEQ_RAMP_DOWN;
          end
          SEQ_RAMP_DOWN: begin
            if (tick && at_zero) begin
              state_q   <= SEQ_COOLDOWN;
              bram_en_q <= 1'b0;
              cd_q      <= CD_LOAD;
            end
          end
          SEQ_COOLDOWN: begin
            if (tick) begin
              // Counter reaching zero on this tick ends the cooldown.
              if (cd_q <= CD_W'(1)) begin
                state_q <= SEQ_IDLE;
                done_q  <= 1'b1;
              end else begin
                cd_q <= cd_q - 1'b1;
              end
            end
          end
          SEQ_FAULT: begin
            // Software must withdraw the request before the block re-arms.
            if (!bus.start_req) state_q <= SEQ_IDLE;
          end
          default: state_q <= SEQ_IDLE;
        endcase
      end
    end
  end

  generate
    if (MSG_ID_W < 8) begin : g_unused_id
      logic unused_id_bits;
      assign unused_id_bits = ^bus.message_id[7:MSG_ID_W];
    end
  endgenerate

  assign bus.bram_addr = {slot_q, off_q};
  assign bus.bram_en   = bram_en_q;
  assign bus.gain      = gain;
  assign bus.on_air    = on_air_q;
  assign bus.seq_state = state_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_am_radio_broadcast_sequencer.sv
module tb_am_radio_broadcast_sequencer;
  localparam int SLOT_W = 3;
  localparam int MID_W  = 4;
  localparam int GMAX   = 255;
  localparam int STEP   = 64;
  localparam int CDT    = 4;
  localparam int OFFMAX = (1 << SLOT_W) - 1;
  localparam int IDLE = 0, RUP = 1, ONA = 2, RDN = 3, CD = 4, FLT = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  am_radio_broadcast_sequencer_if #(.SLOT_W(SLOT_W), .MSG_ID_W(MID_W), .GAIN_W(8)) bus ();

  am_radio_broadcast_sequencer #(
    .CLK_FREQ(125_000_000), .SLOT_W(SLOT_W), .MSG_ID_W(MID_W), .GAIN_W(8),
    .GAIN_MAX(GMAX), .RAMP_STEP(STEP), .COOLDOWN_TICKS(CDT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int failed = 0;

  // Behavioural reference: integer state/gain/offset following the sequencing rules.
  int m_st, m_g, m_off, m_slot, m_cd;
  bit m_en, m_done;

  function automatic void model_reset();
    m_st = IDLE; m_g = 0; m_off = 0; m_slot = 0; m_cd = 0; m_en = 0; m_done = 0;
  endfunction

  function automatic void model_step(bit sr, bit ab, bit tk, int mid, bit lp);
    bit stop_end;
    m_done = 0;
    if (ab) begin
      m_st = FLT; m_g = 0; m_en = 0; m_off = 0;
      return;
    end
    case (m_st)
      IDLE: if (sr) begin m_st = RUP; m_slot = mid % 16; m_off = 0; m_g = 0; m_en = 1; end
      RUP, ONA, RDN: if (tk) begin
        stop_end = (m_off == OFFMAX) && !lp;
        if (m_off != OFFMAX) m_off++;
        else if (lp) m_off = 0;
        if (m_st == RUP) begin
          if (!sr || stop_end) m_st = RDN;
          else begin
            m_g = (m_g + STEP > GMAX) ? GMAX : m_g + STEP;
            if (m_g == GMAX) m_st = ONA;
          end
        end else if (m_st == ONA) begin
          if (!sr || stop_end) m_st = RDN;
        end else begin
          m_g = (m_g - STEP < 0) ? 0 : m_g - STEP;
          if (m_g == 0) begin m_st = CD; m_en = 0; m_cd = CDT; end
        end
      end
      CD: if (tk) begin
        m_cd--;
        if (m_cd <= 0) begin m_st = IDLE; m_done = 1; end
      end
      FLT: if (!sr) m_st = IDLE;
      default: ;
    endcase
  endfunction

  function automatic logic [20:0] exp_vec();
    logic [6:0] a;
    a = m_en ? 7'((m_slot << SLOT_W) + m_off) : 7'd0;
    return {3'(m_st), 8'(m_g), (m_g != 0), m_en, m_done, a};
  endfunction

  function automatic logic [20:0] obs_vec();
    return {bus.seq_state, bus.gain, bus.on_air, bus.bram_en, bus.done,
            (bus.bram_en ? bus.bram_addr : 7'd0)};
  endfunction

  task automatic cyc(input bit sr, input bit ab, input bit tk, input int mid, input bit lp);
    @(negedge clk);
    bus.start_req = sr; bus.abort = ab; bus.sample_tick = tk;
    bus.message_id = 8'(mid); bus.loop_en = lp;
    @(posedge clk);
    model_step(sr, ab, tk, mid, lp);
    #1;
  endtask

  task automatic go_idle();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (obs_vec() !== 21'd0) begin
      failed++; $display("FAIL reset_outputs: got %h required %h", obs_vec(), 21'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_soft_start();
    int exp_g[4];
    exp_g = '{64, 128, 192, 255};
    cyc(1, 0, 0, 3, 1);
    tests++;
    if (obs_vec() !== exp_vec()) begin
      failed++; $display("FAIL start_edge: got %h required %h", obs_vec(), exp_vec());
    end
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 2)) cyc(1, 0, 0, 3, 1);
      cyc(1, 0, 1, 3, 1);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        failed++; $display("FAIL soft_start_model t%0d: got %h required %h", k, obs_vec(), exp_vec());
      end
      tests++;
      if (bus.gain !== 8'(exp_g[k]) || bus.bram_addr !== 7'(3 * 8 + k + 1)) begin
        failed++;
        $display("FAIL soft_start t%0d: gain %0d addr %0d required gain %0d addr %0d",
                 k, bus.gain, bus.bram_addr, exp_g[k], 3 * 8 + k + 1);
      end
    end
    tests++;
    if (bus.seq_state !== 3'd2) begin
      failed++; $display("FAIL on_air_state: got %0d required 2", bus.seq_state);
    end
  endtask

  task automatic test_soft_stop();
    int exp_g[4];
    int dones;
    exp_g = '{191, 127, 63, 0};
    dones = 0;
    cyc(0, 0, 1, 3, 1);
    tests++;
    if (bus.seq_state !== 3'd3 || bus.gain !== 8'd255) begin
      failed++; $display("FAIL stop_edge: state %0d gain %0d required 3 255", bus.seq_state, bus.gain);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 1, 3, 1);
      tests++;
      if (bus.gain !== 8'(exp_g[k]) || obs_vec() !== exp_vec()) begin
        failed++; $display("FAIL soft_stop t%0d: gain %0d vec %h required gain %0d vec %h",
                           k, bus.gain, obs_vec(), exp_g[k], exp_vec());
      end
    end
    for (int k = 0; k < CDT; k++) begin
      tests++;
      if (bus.seq_state !== 3'd4) begin
        failed++; $display("FAIL cooldown t%0d: state %0d required 4", k, bus.seq_state);
      end
      cyc(0, 0, 0, 3, 1);
      dones += int'(bus.done);
      cyc(0, 0, 1, 3, 1);
      dones += int'(bus.done);
    end
    cyc(0, 0, 0, 3, 1);
    dones += int'(bus.done);
    tests++;
    if (dones != 1 || bus.seq_state !== 3'd0) begin
      failed++; $display("FAIL done_pulse: pulses %0d state %0d required 1 0", dones, bus.seq_state);
    end
  endtask

  task automatic test_one_shot();
    int mid;
    mid = $urandom_range(0, 15);
    go_idle();
    cyc(1, 0, 0, mid, 0);
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 0, 1, mid, 0);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        failed++; $display("FAIL one_shot_model t%0d: got %h required %h", k, obs_vec(), exp_vec());
      end
    end
    tests++;
    if (bus.seq_state !== 3'd3 || bus.bram_addr !== 7'(mid * 8 + 7) || bus.gain !== 8'd255) begin
      failed++; $display("FAIL one_shot_end: state %0d addr %0d gain %0d required 3 %0d 255",
                         bus.seq_state, bus.bram_addr, bus.gain, mid * 8 + 7);
    end
    for (int i = 0; i < 40 && m_st != IDLE; i++) cyc(0, 0, 1, mid, 0);
    tests++;
    if (bus.seq_state !== 3'd0 || obs_vec() !== exp_vec()) begin
      failed++; $display("FAIL one_shot_idle: got %h required %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_loop_wrap();
    int mid;
    mid = $urandom_range(0, 15);
    go_idle();
    cyc(1, 0, 0, mid, 1);
    repeat (7) cyc(1, 0, 1, mid, 1);
    tests++;
    if (bus.bram_addr !== 7'(mid * 8 + 7)) begin
      failed++; $display("FAIL loop_pre_wrap: addr %0d required %0d", bus.bram_addr, mid * 8 + 7);
    end
    cyc(1, 0, 1, mid, 1);
    tests++;
    if (bus.bram_addr !== 7'(mid * 8) || bus.gain !== 8'd255 || bus.seq_state !== 3'd2) begin
      failed++; $display("FAIL loop_wrap: addr %0d gain %0d state %0d required %0d 255 2",
                         bus.bram_addr, bus.gain, bus.seq_state, mid * 8);
    end
  endtask

  task automatic test_abort();
    go_idle();
    cyc(1, 0, 0, 6, 1);
    repeat (2) cyc(1, 0, 1, 6, 1);
    cyc(1, 1, 0, 6, 1);
    tests++;
    if (bus.gain !== 8'd0 || bus.bram_en !== 1'b0 || bus.seq_state !== 3'd5 || bus.on_air !== 1'b0) begin
      failed++; $display("FAIL abort: gain %0d en %0d state %0d required 0 0 5",
                         bus.gain, bus.bram_en, bus.seq_state);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 1'($urandom_range(0, 1)), 6, 1);
      tests++;
      if (bus.seq_state !== 3'd5 || obs_vec() !== exp_vec()) begin
        failed++; $display("FAIL fault_hold: state %0d required 5", bus.seq_state);
      end
    end
    cyc(0, 0, 0, 6, 1);
    tests++;
    if (bus.seq_state !== 3'd0) begin
      failed++; $display("FAIL fault_release: state %0d required 0", bus.seq_state);
    end
  endtask

  task automatic test_reversal();
    int exp_g[3];
    exp_g = '{128, 64, 0};
    go_idle();
    cyc(1, 0, 0, 2, 1);
    repeat (2) cyc(1, 0, 1, 2, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(k != 0, 0, 1, 2, 1);
      tests++;
      if (bus.gain !== 8'(exp_g[k]) || obs_vec() !== exp_vec()) begin
        failed++; $display("FAIL reversal t%0d: gain %0d required %0d", k, bus.gain, exp_g[k]);
      end
    end
    for (int k = 0; k < CDT; k++) begin
      tests++;
      if (bus.seq_state !== 3'd4) begin
        failed++; $display("FAIL reversal_cooldown t%0d: state %0d required 4", k, bus.seq_state);
      end
      cyc(1, 0, 1, 2, 1);
    end
    tests++;
    if (bus.seq_state !== 3'd0 || bus.done !== 1'b1) begin
      failed++; $display("FAIL reversal_idle: state %0d done %0d required 0 1", bus.seq_state, bus.done);
    end
    cyc(1, 0, 0, 2, 1);
    tests++;
    if (bus.seq_state !== 3'd1) begin
      failed++; $display("FAIL restart: state %0d required 1", bus.seq_state);
    end
  endtask

  task automatic test_back_to_back();
    go_idle();
    cyc(1, 0, 0, 5, 1);
    for (int k = 0; k < 6; k++) begin
      cyc(1, 0, 1, 9 + k, 1);
      tests++;
      if (bus.bram_addr[6:3] !== 4'd5 || obs_vec() !== exp_vec()) begin
        failed++; $display("FAIL slot_latch t%0d: slot %0d required 5", k, bus.bram_addr[6:3]);
      end
    end
  endtask

  task automatic test_async_reset();
    go_idle();
    cyc(1, 0, 0, 1, 1);
    repeat (4) cyc(1, 0, 1, 1, 1);
    #2;
    rst_n = 1'b0;
    bus.start_req = 0; bus.sample_tick = 0; bus.abort = 0;
    #1;
    tests++;
    if (bus.gain !== 8'd0 || bus.bram_en !== 1'b0 || bus.on_air !== 1'b0 || bus.seq_state !== 3'd0) begin
      failed++; $display("FAIL async_reset: gain %0d en %0d on_air %0d state %0d required 0 0 0 0",
                         bus.gain, bus.bram_en, bus.on_air, bus.seq_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    bit sr, lp;
    sr = 1; lp = 0;
    go_idle();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) sr = !sr;
      if ($urandom_range(0, 29) == 0) lp = !lp;
      cyc(sr, $urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 255), lp);
      tests++;
      if (obs_vec() !== exp_vec()) begin
        failed++; $display("FAIL random c%0d: got %h required %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start_req = 0; bus.abort = 0; bus.sample_tick = 0; bus.message_id = 8'd0; bus.loop_en = 0;
    model_reset();
    test_reset();
    test_soft_start();
    test_soft_stop();
    test_one_shot();
    test_loop_wrap();
    test_abort();
    test_reversal();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/am_radio_broadcast_sequencer.md
# am_radio_broadcast_sequencer

Sequences one broadcast on the AM radio transmit path.
- Turns the qualified broadcast request and the watchdog fault into a soft-start / soft-stop carrier gain envelope.
- Generates the BRAM read address for the selected stored message.
- Sits between the control/status register block and the AM modulator. Its gain output scales the modulator output, and its address/enable drive the message BRAM read port.

## Interface
Parameters:
- CLK_FREQ, 125_000_000: system clock in Hz (documentation only; not used in logic).
- SLOT_W, 10: log2 of words per message slot (1024 samples).
- MSG_ID_W, 4: message-ID bits used for slot select (16 slots).
- GAIN_W, 8: gain output width.
- GAIN_MAX, 255: full-scale gain.
- RAMP_STEP, 1: gain change per sample tick during ramps; must be ≥1.
- COOLDOWN_TICKS, 64: sample ticks the block stays silent before it can re-arm.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- start_req  in  1  level; broadcast requested and qualified (broadcast_active).
- abort  in  1  level; watchdog triggered, hard kill.
- sample_tick  in  1  one-cycle audio-rate strobe.
- message_id  in  8  message select; only bits [MSG_ID_W-1:0] are used.
- loop_en  in  1  1 = repeat message, 0 = play message once.
- bram_addr  out  MSG_ID_W+SLOT_W  registered read address {slot, offset}.
- bram_en  out  1  registered BRAM read enable.
- gain  out  GAIN_W  registered carrier gain.
- on_air  out  1  high while gain > 0.
- seq_state  out  3  current state encoding, for the status register.
- done  out  1  one-cycle pulse on COOLDOWN→IDLE.

## Operation
- States:
  - IDLE=0, RAMP_UP=1, ON_AIR=2, RAMP_DOWN=3, COOLDOWN=4, FAULT=5.
  - Reset state is IDLE.
  - All outputs reset to 0.
- IDLE → RAMP_UP: on the first clk with start_req=1 and abort=0; no tick is required.
  - message_id[MSG_ID_W-1:0] is latched into the slot register; later changes are ignored until the next start.
  - Offset and gain are cleared to 0.
- Address generation:
  - bram_en=1 in RAMP_UP, ON_AIR and RAMP_DOWN.
  - Offset advances by 1 on each sample_tick in those states.
  - At offset 2^SLOT_W−1, the next tick handles the wrap:
    - loop_en=1: offset wraps to 0.
    - loop_en=0: offset holds, and the state goes to RAMP_DOWN if not already there.
- RAMP_UP:
  - Each tick: gain = min(gain+RAMP_STEP, GAIN_MAX), computed GAIN_W+1 bits wide, then saturated.
  - When the new gain equals GAIN_MAX, go to ON_AIR.
  - start_req=0 at a tick → RAMP_DOWN from the current gain.
- ON_AIR: gain holds at GAIN_MAX; start_req=0 at a tick → RAMP_DOWN.
- RAMP_DOWN:
  - Each tick: gain = max(gain−RAMP_STEP, 0).
  - When the new gain is 0: go to COOLDOWN, bram_en=0, load cooldown counter = COOLDOWN_TICKS.
  - start_req re-asserting during RAMP_DOWN is ignored; the ramp continues down.
- COOLDOWN:
  - Counter decrements per tick.
  - At 0 → IDLE with done=1 for one cycle.
  - start_req is ignored.
- abort (highest priority, any state):
  - Next clk: state FAULT, gain=0, bram_en=0, offset=0; no tick is needed.
- FAULT → IDLE: on the first clk with abort=0 and start_req=0. Software must drop the request before re-arming.
- Simultaneous events:
  - abort beats everything.
  - Wrap end-of-message and start_req=0 on the same tick → RAMP_DOWN, once.
  - A tick on the IDLE→RAMP_UP edge is not counted.
- on_air = (gain != 0), registered alongside gain.

## Timing
- Outputs are registered and update on the clk edge after the causing tick or event.
- Ramp duration is ceil(GAIN_MAX/RAMP_STEP) ticks in each direction.
- bram_addr is valid with bram_en; BRAM data is available one clk later (downstream concern).
- Reset mid-broadcast: gain drops to 0 asynchronously; no ramp.

## Structure
- Shared package am_radio_pkg holds:
  - the state encodings SEQ_IDLE…SEQ_FAULT;
  - the SEQ_STATE_W=3 constant;
  - the status-field bit positions for seq_state and on_air.
- Sub-module am_gain_ramp: saturating up/down counter with inputs up, down, clr and tick; parameters GAIN_W, GAIN_MAX, RAMP_STEP; outputs gain, at_max, at_zero.
- The FSM and address counter remain in the top module.

## Test plan
Bench settings unless noted: RAMP_STEP=64, GAIN_MAX=255, COOLDOWN_TICKS=4.
- Soft start:
  - Stimulus: message_id=3, raise start_req, give ticks.
  - Response: gain 64,128,192,255; ON_AIR after tick 4; bram_addr = 3·1024 + offset, offset incrementing per tick.
- Soft stop:
  - Stimulus: drop start_req in ON_AIR.
  - Response: gain 191,127,63,0; then COOLDOWN for 4 ticks; done pulses once; seq_state=0.
- One-shot end:
  - Stimulus: loop_en=0, SLOT_W=3.
  - Response: after offset 7 the next tick enters RAMP_DOWN and offset holds at 7.
  - Same test with loop_en=1: offset goes 7→0 and gain stays 255.
- Watchdog abort:
  - Stimulus: assert abort mid-ramp at gain=128 with no tick.
  - Response: next clk gain=0, bram_en=0, seq_state=5.
  - With start_req still 1 after abort drops: stays in FAULT. After start_req=0: IDLE.
- Reversal and ignore:
  - Stimulus: drop start_req at gain=128 in RAMP_UP, then re-raise it during RAMP_DOWN.
  - Response: ramp continues 64,0, enters COOLDOWN, and a restart happens only after IDLE.
- Async reset mid ON_AIR:
  - Stimulus: pulse rst_n low between clk edges.
  - Response: gain, bram_en and on_air go to 0 immediately; seq_state=0.
